// File: rtl/sat_add_pkg.sv
// Shared types and helpers for the saturating-adder arbiter.
// Saturation limits, overflow kind and stats counter width.
package sat_add_pkg;

  localparam int SAT_CNT_W = 16;

  typedef enum logic [1:0] {
    OVF_NONE,
    OVF_POS,
    OVF_NEG
  } ovf_e;

  function automatic logic [31:0] sat_max(input int w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return 32'h1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational W-bit signed saturating adder.
// Clamps to MAX/MIN on same-sign overflow.
module sat_add_core
  import sat_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output ovf_e         ovf
);

  logic [W-1:0] w_raw;
  logic         w_pos;
  logic         w_neg;

  assign w_raw = a + b;
  assign w_pos = !a[W-1] && !b[W-1] && w_raw[W-1];
  assign w_neg = a[W-1] && b[W-1] && !w_raw[W-1];

  // Pick wrap sum or clamp value from the overflow kind
  always_comb begin
    sum = w_raw;
    ovf = OVF_NONE;
    unique case (1'b1)
      w_pos: begin
        sum = W'(sat_max(W));
        ovf = OVF_POS;
      end
      w_neg: begin
        sum = W'(sat_min(W));
        ovf = OVF_NEG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin share of one saturating adder, one result slot.
// Optional saturation counter: SAT_ADD_ARBITER_STATS_EN.
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter  int W       = 4,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_rdy,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [W-1:0]         res_sum,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_sat
`ifdef SAT_ADD_ARBITER_STATS_EN
  ,
  output logic [SAT_CNT_W-1:0] sat_cnt
`endif
);

  logic            r_vld;
  logic [W-1:0]    r_sum;
  logic [ID_W-1:0] r_id;
  logic            r_sat;
  logic [ID_W-1:0] r_rr;

  logic            w_free;
  logic            w_hit;
  logic            w_gnt;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_rr_nxt;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    w_sum;
  ovf_e            w_ovf;
  logic            w_sat;

  function automatic logic [ID_W-1:0] wrap_idx(
    input logic [ID_W-1:0] base,
    input int              k
  );
    int j;
    j = int'(base) + k;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return ID_W'(j);
  endfunction

  assign w_free = !r_vld || res_rdy;

  // First valid requester at or after the rr pointer, with wrap
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && req_vld[wrap_idx(r_rr, k)]) begin
        w_hit = 1'b1;
        w_idx = wrap_idx(r_rr, k);
      end
    end
  end

  assign w_gnt   = w_free && w_hit;
  assign req_rdy = w_gnt ? (NUM_REQ'(1) << w_idx) : '0;

  assign w_rr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ?
                    '0 : w_idx + 1'b1;

  assign w_a = req_a[int'(w_idx)*W +: W];
  assign w_b = req_b[int'(w_idx)*W +: W];

  sat_add_core #(
    .W(W)
  ) u_core (
    .a  (w_a),
    .b  (w_b),
    .sum(w_sum),
    .ovf(w_ovf)
  );

  assign w_sat = (w_ovf != OVF_NONE);

  // Result slot: load on grant, empty on drain, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_sum <= '0;
      r_id  <= '0;
      r_sat <= 1'b0;
      r_rr  <= '0;
    end else if (w_gnt) begin
      r_vld <= 1'b1;
      r_sum <= w_sum;
      r_id  <= w_idx;
      r_sat <= w_sat;
      r_rr  <= w_rr_nxt;
    end else if (res_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign res_vld = r_vld;
  assign res_sum = r_sum;
  assign res_id  = r_id;
  assign res_sat = r_sat;

`ifdef SAT_ADD_ARBITER_STATS_EN
  logic [SAT_CNT_W-1:0] r_cnt;

  // Count saturating transfers, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_gnt && w_sat && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat_cnt = r_cnt;
`endif

endmodule
